// File: rtl/hs32_mem_pkg.sv
// Shared types and helpers for the hs32 SRAM controller: FSM states,
// lane one-hot encoding and byte extraction from a 32-bit macro dout.
package hs32_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH0  = 3'd1,
        ST_PH1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_ACK  = 3'd4
    } state_e;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
        byte_extract = word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/hs32_sram_lane_sel.sv
// Picks one byte lane out of each macro's dout and joins them into a halfword
// (macro0 supplies the high byte, macro1 the low byte).
module hs32_sram_lane_sel
    import hs32_mem_pkg::*;
(
    input  logic [31:0] dtr0,
    input  logic [31:0] dtr1,
    input  logic [1:0]  lane,
    output logic [15:0] half
);

    assign half = {byte_extract(dtr0, lane), byte_extract(dtr1, lane)};

endmodule

// File: rtl/hs32_sram_ctl.sv
// Memory-side stage: one 32-bit stb/ack request becomes two halfword phases
// on a pair of byte-wide-lane SRAM macros with registered SRAM-side outputs.
module hs32_sram_ctl
    import hs32_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          SRAM_AW   = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   i_stb,
    input  logic                   i_rw,
    input  logic [31:0]            i_addr,
    input  logic [3:0]             i_sel,
    input  logic [31:0]            i_dtw,
    output logic [31:0]            o_dtr,
    output logic                   o_ack,
    output logic                   o_err,
    output logic                   o_busy,
    output logic [1:0]             sram_wen,
    output logic [7:0]             sram_mask,
    output logic [2*SRAM_AW-1:0]   sram_addr,
    output logic [15:0]            sram_dtw,
    input  logic [31:0]            sram_dtr0,
    input  logic [31:0]            sram_dtr1
);

    state_e               state, state_nx;
    logic [SRAM_AW:0]     req_w;
    logic                 req_rw;
    logic [3:0]           req_sel;
    logic [31:0]          req_dtw;
    logic                 err_q;
    logic [1:0]           ph_lane, dout_lane;
    logic                 hit, accept;
    logic                 addr_unused;

    // Request source: live inputs while accepting, captured copy afterwards.
    logic [SRAM_AW:0]     src_w;
    logic                 src_rw;
    logic [3:0]           src_sel;
    logic [31:0]          src_dtw;

    logic                 drive, phase, hi_sel, lo_sel;
    logic [1:0]           lane_d;
    logic [3:0]           oh;
    logic [1:0]           wen_d;
    logic [7:0]           mask_d;
    logic [2*SRAM_AW-1:0] addr_d;
    logic [15:0]          dtw_d;
    logic [15:0]          rd_half;

    assign addr_unused = ^i_addr[1:0];
    assign hit    = (i_addr[31:SRAM_AW+3] == BASE_ADDR[31:SRAM_AW+3]);
    assign accept = (state == ST_IDLE) && i_stb;

    assign src_w   = (state == ST_IDLE) ? i_addr[SRAM_AW+2:2] : req_w;
    assign src_rw  = (state == ST_IDLE) ? i_rw  : req_rw;
    assign src_sel = (state == ST_IDLE) ? i_sel : req_sel;
    assign src_dtw = (state == ST_IDLE) ? i_dtw : req_dtw;

    always_comb begin
        state_nx = state;
        case (state)
            // A miss spends one SRAM-idle cycle in RD2 so it completes at a fixed latency.
            ST_IDLE: if (i_stb) state_nx = hit ? ST_PH0 : ST_RD2;
            ST_PH0:  state_nx = ST_PH1;
            ST_PH1:  state_nx = req_rw ? ST_ACK : ST_RD2;
            ST_RD2:  state_nx = ST_ACK;
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // SRAM-side values for the phase about to be presented on the next edge.
    always_comb begin
        drive  = 1'b0;
        phase  = 1'b0;
        lane_d = 2'b00;
        oh     = 4'b0000;
        hi_sel = 1'b0;
        lo_sel = 1'b0;
        wen_d  = 2'b11;
        mask_d = 8'h00;
        addr_d = '0;
        dtw_d  = 16'h0000;
        if (state_nx == ST_PH0 || state_nx == ST_PH1) begin
            drive  = 1'b1;
            phase  = (state_nx == ST_PH1);
            lane_d = {src_w[0], phase};
            oh     = lane_onehot(lane_d);
            hi_sel = phase ? src_sel[1] : src_sel[3];
            lo_sel = phase ? src_sel[0] : src_sel[2];
            wen_d  = {~(src_rw & hi_sel), ~(src_rw & lo_sel)};
            mask_d = {oh & {4{~src_rw | hi_sel}}, oh & {4{~src_rw | lo_sel}}};
            addr_d = {src_w[SRAM_AW:1], src_w[SRAM_AW:1]};
            dtw_d  = phase ? src_dtw[15:0] : src_dtw[31:16];
        end
    end

    hs32_sram_lane_sel u_lane_sel (
        .dtr0 (sram_dtr0),
        .dtr1 (sram_dtr1),
        .lane (dout_lane),
        .half (rd_half)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            req_w     <= '0;
            req_rw    <= 1'b0;
            req_sel   <= 4'h0;
            req_dtw   <= 32'h0;
            err_q     <= 1'b0;
            ph_lane   <= 2'b00;
            dout_lane <= 2'b00;
            o_dtr     <= 32'h0;
            sram_wen  <= 2'b11;
            sram_mask <= 8'h00;
            sram_addr <= '0;
            sram_dtw  <= 16'h0000;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_w   <= i_addr[SRAM_AW+2:2];
                req_rw  <= i_rw;
                req_sel <= i_sel;
                req_dtw <= i_dtw;
                err_q   <= ~hit;
            end
            // dout carries the previous cycle's address, so its lane trails by one.
            ph_lane   <= drive ? lane_d : 2'b00;
            dout_lane <= ph_lane;
            if (accept && !hit)
                o_dtr <= 32'h0;
            else if (state == ST_PH1 && !req_rw)
                o_dtr[31:16] <= rd_half;
            else if (state == ST_RD2 && !err_q)
                o_dtr[15:0] <= rd_half;
            sram_wen  <= wen_d;
            sram_mask <= mask_d;
            sram_addr <= addr_d;
            sram_dtw  <= dtw_d;
        end
    end

    assign o_ack  = (state == ST_ACK);
    assign o_err  = o_ack & err_q;
    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hs32_sram_ctl.sv
// Bench for hs32_sram_ctl: behavioural macro pair, directed requests with
// hand-computed phase outputs and responses, and an ack-driven scoreboard.
module tb_hs32_sram_ctl;

    localparam int W = 34; // {check_data, err, dtr}

    logic        wb_clk_i, wb_rst_ni;
    logic        i_stb, i_rw;
    logic [31:0] i_addr, i_dtw;
    logic [3:0]  i_sel;
    logic [31:0] o_dtr;
    logic        o_ack, o_err, o_busy;
    logic [1:0]  sram_wen;
    logic [7:0]  sram_mask;
    logic [15:0] sram_addr, sram_dtw;
    logic [31:0] sram_dtr0, sram_dtr1;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    hs32_sram_ctl #(.BASE_ADDR(32'h0000_0000), .SRAM_AW(8)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .i_stb     (i_stb),
        .i_rw      (i_rw),
        .i_addr    (i_addr),
        .i_sel     (i_sel),
        .i_dtw     (i_dtw),
        .o_dtr     (o_dtr),
        .o_ack     (o_ack),
        .o_err     (o_err),
        .o_busy    (o_busy),
        .sram_wen  (sram_wen),
        .sram_mask (sram_mask),
        .sram_addr (sram_addr),
        .sram_dtw  (sram_dtw),
        .sram_dtr0 (sram_dtr0),
        .sram_dtr1 (sram_dtr1)
    );

    // Clock
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Macro pair: byte lanes under wmask, byte replicated, 1-cycle read latency
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    initial begin
        for (int r = 0; r < 256; r++) begin
            mem0[r] = 32'h0;
            mem1[r] = 32'h0;
        end
        sram_dtr0 = 32'h0;
        sram_dtr1 = 32'h0;
    end

    always @(posedge wb_clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (!sram_wen[1] && sram_mask[4+l]) mem0[sram_addr[15:8]][8*l +: 8] <= sram_dtw[15:8];
            if (!sram_wen[0] && sram_mask[l])   mem1[sram_addr[7:0]][8*l +: 8]  <= sram_dtw[7:0];
        end
        sram_dtr0 <= mem0[sram_addr[15:8]];
        sram_dtr1 <= mem1[sram_addr[7:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rsp(input logic chk_d, input logic err, input logic [31:0] d);
        rsp = {chk_d, err, d};
    endfunction

    // Scoreboard monitor
    always @(negedge wb_clk_i) begin
        logic [W-1:0] e;
        if (wb_rst_ni && o_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with empty queue at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", {63'h0, o_err}, {63'h0, e[32]});
                if (e[33]) chk("rsp_dtr", {32'h0, o_dtr}, {32'h0, e[31:0]});
            end
        end
    end

    // Driver: issue one request, check phase outputs and ack latency
    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] dtw, input int exp_lat, input logic [7:0] row,
                          input logic [7:0] m0, input logic [7:0] m1,
                          input logic [1:0] wn0, input logic [1:0] wn1,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [W-1:0] exp_rsp);
        bit got = 0;
        exp_q.push_back(exp_rsp);
        @(negedge wb_clk_i);
        i_stb = 1'b1; i_rw = rw; i_addr = addr; i_sel = sel; i_dtw = dtw;
        @(posedge wb_clk_i);
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge wb_clk_i);
            if (exp_lat == 2) begin
                chk("miss_wen", {62'h0, sram_wen}, 64'h3);
                chk("miss_mask", {56'h0, sram_mask}, 64'h0);
            end else if (c == 1 || c == 2) begin
                chk("ph_addr", {48'h0, sram_addr}, {48'h0, row, row});
                chk("ph_mask", {56'h0, sram_mask}, {56'h0, (c == 1) ? m0 : m1});
                chk("ph_wen", {62'h0, sram_wen}, {62'h0, (c == 1) ? wn0 : wn1});
                if (rw) chk("ph_dtw", {48'h0, sram_dtw}, {48'h0, (c == 1) ? d0 : d1});
            end else if (c == 3 && exp_lat == 4) begin
                chk("rd2_idle", {54'h0, sram_wen, sram_mask}, {54'h0, 2'b11, 8'h00});
            end
            if (o_ack) begin
                got = 1;
                chk("ack_lat", 64'(c), 64'(exp_lat));
                i_stb = 1'b0;
            end
        end
        if (!got) begin
            chk("ack_timeout", 64'h0, 64'h1);
            i_stb = 1'b0;
        end
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        i_stb = 1'b0; i_rw = 1'b0; i_addr = 32'h0; i_sel = 4'h0; i_dtw = 32'h0;

        // Reset values
        repeat (3) @(negedge wb_clk_i);
        chk("rst_ack_err_busy", {61'h0, o_ack, o_err, o_busy}, 64'h0);
        chk("rst_dtr", {32'h0, o_dtr}, 64'h0);
        chk("rst_wen_mask", {54'h0, sram_wen, sram_mask}, {54'h0, 2'b11, 8'h00});
        chk("rst_addr_dtw", {32'h0, sram_addr, sram_dtw}, 64'h0);
        wb_rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            chk("idle_sram", {53'h0, o_busy, sram_wen, sram_mask}, {53'h0, 1'b0, 2'b11, 8'h00});
        end

        //     rw    addr          sel      dtw        lat row    m0     m1     wn0    wn1    d0        d1        response
        do_req(1'b1, 32'h0000_0004, 4'hF,   32'hDEADBEEF, 3, 8'h00, 8'h44, 8'h88, 2'b00, 2'b00, 16'hDEAD, 16'hBEEF, rsp(0, 0, 32'h0));
        do_req(1'b0, 32'h0000_0004, 4'h0,   32'h0,        4, 8'h00, 8'h44, 8'h88, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'hDEADBEEF));
        do_req(1'b1, 32'h0000_0000, 4'hF,   32'h01234567, 3, 8'h00, 8'h11, 8'h22, 2'b00, 2'b00, 16'h0123, 16'h4567, rsp(0, 0, 32'h0));
        do_req(1'b0, 32'h0000_0000, 4'h0,   32'h0,        4, 8'h00, 8'h11, 8'h22, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'h01234567));
        do_req(1'b1, 32'h0000_0008, 4'hF,   32'hCAFEF00D, 3, 8'h01, 8'h11, 8'h22, 2'b00, 2'b00, 16'hCAFE, 16'hF00D, rsp(0, 0, 32'h0));
        do_req(1'b0, 32'h0000_0008, 4'h0,   32'h0,        4, 8'h01, 8'h11, 8'h22, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'hCAFEF00D));
        do_req(1'b1, 32'h0000_07FC, 4'hF,   32'hAABBCCDD, 3, 8'hFF, 8'h44, 8'h88, 2'b00, 2'b00, 16'hAABB, 16'hCCDD, rsp(0, 0, 32'h0));
        do_req(1'b1, 32'h0000_07FC, 4'b0101, 32'h11223344, 3, 8'hFF, 8'h04, 8'h08, 2'b10, 2'b10, 16'h1122, 16'h3344, rsp(0, 0, 32'h0));
        do_req(1'b0, 32'h0000_07FC, 4'h0,   32'h0,        4, 8'hFF, 8'h44, 8'h88, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'hAA22CC44));
        do_req(1'b1, 32'h0000_0008, 4'b1010, 32'h99887766, 3, 8'h01, 8'h10, 8'h20, 2'b01, 2'b01, 16'h9988, 16'h7766, rsp(0, 0, 32'h0));
        do_req(1'b0, 32'h0000_0008, 4'h0,   32'h0,        4, 8'h01, 8'h11, 8'h22, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'h99FE770D));
        do_req(1'b0, 32'h0000_0800, 4'h0,   32'h0,        2, 8'h00, 8'h00, 8'h00, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 1, 32'h0));
        do_req(1'b1, 32'hFFFF_FFF0, 4'hF,   32'h12345678, 2, 8'h00, 8'h00, 8'h00, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 1, 32'h0));
        do_req(1'b0, 32'h0000_0004, 4'h0,   32'h0,        4, 8'h00, 8'h44, 8'h88, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'hDEADBEEF));

        // Reset during PH1 of a write: phase 0 lands, phase 1 does not
        @(negedge wb_clk_i);
        i_stb = 1'b1; i_rw = 1'b1; i_addr = 32'h0000_0004; i_sel = 4'hF; i_dtw = 32'h55667788;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("mid_busy_before", {63'h0, o_busy}, 64'h1);
        wb_rst_ni = 1'b0;
        i_stb = 1'b0;
        #1;
        chk("mid_rst_ctl", {61'h0, o_ack, o_err, o_busy}, 64'h0);
        chk("mid_rst_dtr", {32'h0, o_dtr}, 64'h0);
        chk("mid_rst_wen_mask", {54'h0, sram_wen, sram_mask}, {54'h0, 2'b11, 8'h00});
        chk("mid_rst_addr_dtw", {32'h0, sram_addr, sram_dtw}, 64'h0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        do_req(1'b0, 32'h0000_0004, 4'h0,   32'h0,        4, 8'h00, 8'h44, 8'h88, 2'b11, 2'b11, 16'h0,    16'h0,    rsp(1, 0, 32'h5566BEEF));

        repeat (3) @(negedge wb_clk_i);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
